// File: rtl/count_seq_pkg.sv
// count_seq_pkg
// Shared types and constants for the count sequencer and the panel display
// logic: the FSM state and command encodings, plus the sixteen hexadecimal
// seven-segment glyphs (bit order gfedcba, active-high segments).
package count_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_RUN_UP   = 2'b01,
        OP_RUN_DOWN = 2'b10,
        OP_STOP     = 2'b11
    } seq_op_t;

    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

endpackage

// File: rtl/count_sequencer_counter.sv
// updown_counter
// Counter datapath for the sequencer. Holds the count register and computes
// the value of the next step, wrapping modulo 2^NBITS_COUNT or, in bounce
// mode, folding back from the range limits.
// Ports:
//   clk_2, reset_n  clock and asynchronous active-low reset
//   load            load strobe; count takes load_value at the edge
//   load_value      value to load
//   enable          step strobe; count takes next_count at the edge
//   up              step direction, 1 = up
//   bounce          fold back at the limits instead of wrapping
//   count           current count
//   next_count      value the next step would produce
//   reverse         high when the next step hits a limit in bounce mode,
//                   telling the sequencer to flip its direction
module updown_counter
    import count_seq_pkg::*;
#(
    parameter int NBITS_COUNT = 4
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [NBITS_COUNT-1:0] load_value,
    input  logic                   enable,
    input  logic                   up,
    input  logic                   bounce,
    output logic [NBITS_COUNT-1:0] count,
    output logic [NBITS_COUNT-1:0] next_count,
    output logic                   reverse
);

    localparam logic [NBITS_COUNT-1:0] MAX_COUNT = '1;
    localparam logic [NBITS_COUNT-1:0] ONE       = NBITS_COUNT'(1);

    // At a limit, bounce mode lands one step back inside the range so the
    // limit value is shown for exactly one step before the count retreats.
    always_comb begin
        next_count = count;
        reverse    = 1'b0;
        if (up) begin
            if (count == MAX_COUNT) begin
                if (bounce) begin
                    next_count = MAX_COUNT - ONE;
                    reverse    = 1'b1;
                end else begin
                    next_count = '0;
                end
            end else begin
                next_count = count + ONE;
            end
        end else begin
            if (count == '0) begin
                if (bounce) begin
                    next_count = ONE;
                    reverse    = 1'b1;
                end else begin
                    next_count = MAX_COUNT;
                end
            end else begin
                next_count = count - ONE;
            end
        end
    end

    // Load wins over a step; the sequencer never asserts both together.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
// Sequencing controller for the up/down counter datapath. Commands arrive
// over a valid/ready handshake; while running, a prescaler paces the steps.
// Optional bounce (ping-pong) and stop-at-target behaviour.
// Ports:
//   clk_2, reset_n   clock and asynchronous active-low reset
//   cmd_valid/ready  command handshake, accepted when both are high
//   cmd_op           00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 STOP
//   cmd_data         LOAD value
//   bounce           reverse direction at the range limits
//   target_en/target stop in DONE when a step lands on target
//   count, dir_up    current count and direction
//   running, done    RUN state flag, one-cycle target-reached pulse
//   state            FSM state encoding for the LCD
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int NBITS_COUNT = 4,
    parameter int PRESCALE    = 4
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [NBITS_COUNT-1:0] cmd_data,
    input  logic                   bounce,
    input  logic                   target_en,
    input  logic [NBITS_COUNT-1:0] target,
    output logic [NBITS_COUNT-1:0] count,
    output logic                   dir_up,
    output logic                   running,
    output logic                   done,
    output logic [1:0]             state
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    seq_state_t             state_r, state_nx;
    logic                   dir_up_r, dir_up_nx;
    logic [PS_W-1:0]        prescale_r, prescale_nx;
    logic [NBITS_COUNT-1:0] load_data_r, load_data_nx;
    logic                   step_en;
    logic                   reverse;
    logic [NBITS_COUNT-1:0] next_count;
    seq_op_t                op;
    logic                   accept;
    logic                   tick;

    assign op     = seq_op_t'(cmd_op);
    assign accept = cmd_valid && cmd_ready;
    assign tick   = (prescale_r == PS_LAST);

    // All outputs decode from registered state only.
    assign cmd_ready = (state_r == ST_IDLE) || (state_r == ST_RUN);
    assign running   = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);
    assign state     = state_r;
    assign dir_up    = dir_up_r;

    // Next-state logic. In RUN an accepted command outranks a pending tick,
    // so the step on that edge is dropped. Every way into RUN zeroes the
    // prescaler so the first step always lands PRESCALE edges later.
    always_comb begin
        state_nx     = state_r;
        dir_up_nx    = dir_up_r;
        prescale_nx  = prescale_r;
        load_data_nx = load_data_r;
        step_en      = 1'b0;
        unique case (state_r)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_LOAD: begin
                            state_nx     = ST_LOAD;
                            load_data_nx = cmd_data;
                        end
                        OP_RUN_UP: begin
                            state_nx    = ST_RUN;
                            dir_up_nx   = 1'b1;
                            prescale_nx = '0;
                        end
                        OP_RUN_DOWN: begin
                            state_nx    = ST_RUN;
                            dir_up_nx   = 1'b0;
                            prescale_nx = '0;
                        end
                        OP_STOP: begin
                            state_nx = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (accept) begin
                    prescale_nx = '0;
                    unique case (op)
                        OP_LOAD: begin
                            state_nx     = ST_LOAD;
                            load_data_nx = cmd_data;
                        end
                        OP_RUN_UP: begin
                            dir_up_nx = 1'b1;
                        end
                        OP_RUN_DOWN: begin
                            dir_up_nx = 1'b0;
                        end
                        OP_STOP: begin
                            state_nx = ST_IDLE;
                        end
                    endcase
                end else if (tick) begin
                    step_en     = 1'b1;
                    prescale_nx = '0;
                    if (reverse) begin
                        dir_up_nx = ~dir_up_r;
                    end
                    if (target_en && (next_count == target)) begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    prescale_nx = prescale_r + PS_W'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, direction, prescaler and latched load value.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            dir_up_r    <= 1'b1;
            prescale_r  <= '0;
            load_data_r <= '0;
        end else begin
            state_r     <= state_nx;
            dir_up_r    <= dir_up_nx;
            prescale_r  <= prescale_nx;
            load_data_r <= load_data_nx;
        end
    end

    updown_counter #(
        .NBITS_COUNT(NBITS_COUNT)
    ) u_counter (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .load       (state_r == ST_LOAD),
        .load_value (load_data_r),
        .enable     (step_en),
        .up         (dir_up_r),
        .bounce     (bounce),
        .count      (count),
        .next_count (next_count),
        .reverse    (reverse)
    );

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
// Scoreboard bench for count_sequencer (NBITS_COUNT=4, PRESCALE=4).
// Expectations are queued against an edge number when a command is issued
// and compared two time units after the following falling clock edge.
module tb_count_sequencer;
    import count_seq_pkg::*;

    localparam int F_COUNT = 0;
    localparam int F_DIR   = 1;
    localparam int F_RUN   = 2;
    localparam int F_DONE  = 3;
    localparam int F_STATE = 4;
    localparam int F_READY = 5;

    typedef struct {
        int    cyc;
        string tag;
        int    field;
        int    value;
    } exp_t;

    logic       clk_2;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       bounce;
    logic       target_en;
    logic [3:0] target;
    logic [3:0] count;
    logic       dir_up;
    logic       running;
    logic       done;
    logic [1:0] seq_state;

    int   edge_cnt    = 0;
    int   check_count = 0;
    int   pass_count  = 0;
    exp_t sb[$];
    exp_t mon_e;

    count_sequencer #(
        .NBITS_COUNT(4),
        .PRESCALE   (4)
    ) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .bounce    (bounce),
        .target_en (target_en),
        .target    (target),
        .count     (count),
        .dir_up    (dir_up),
        .running   (running),
        .done      (done),
        .state     (seq_state)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d (edge %0d)", tag, observed, expected, edge_cnt);
        end
    endtask

    function automatic int read_field(input int f);
        case (f)
            F_COUNT: return int'(count);
            F_DIR:   return int'(dir_up);
            F_RUN:   return int'(running);
            F_DONE:  return int'(done);
            F_STATE: return int'(seq_state);
            default: return int'(cmd_ready);
        endcase
    endfunction

    function automatic void expect_at(input int cyc, input string tag, input int field, input int value);
        exp_t e;
        e.cyc   = cyc;
        e.tag   = tag;
        e.field = field;
        e.value = value;
        sb.push_back(e);
    endfunction

    // Compare every queued expectation whose edge has arrived.
    always @(negedge clk_2) begin
        #2;
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            mon_e = sb.pop_front();
            check_output(mon_e.tag, read_field(mon_e.field), mon_e.value);
        end
    end

    // Present a command at a falling edge and hold it until it is taken;
    // accept_edge is the rising edge that took it.
    task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] data, output int accept_edge);
        bit taken;
        taken       = 1'b0;
        accept_edge = -1;
        cmd_op      = op;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (cmd_ready) begin
                accept_edge = edge_cnt + 1;
                taken       = 1'b1;
            end
            @(negedge clk_2);
        end
        cmd_valid = 1'b0;
        if (!taken) check_output("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 100;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk_2);
            budget--;
        end
        if (sb.size() > 0) begin
            check_output("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk_2);
    endtask

    task automatic do_load(input logic [3:0] v, input string tag);
        int t;
        apply_stimulus(OP_LOAD, v, t);
        expect_at(t + 1, tag, F_COUNT, int'(v));
        wait_drain();
    endtask

    task automatic do_stop(input string tag);
        int t;
        apply_stimulus(OP_STOP, 4'd0, t);
        expect_at(t, tag, F_RUN, 0);
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int s;
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'd0;
        bounce    = 1'b0;
        target_en = 1'b0;
        target    = 4'd0;
        #1 reset_n = 1'b0;
        #1;
        check_output("rst_count", int'(count), 0);
        check_output("rst_dir", int'(dir_up), 1);
        check_output("rst_running", int'(running), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_ready", int'(cmd_ready), 1);
        check_output("rst_state", int'(seq_state), 0);
        @(negedge clk_2);
        @(negedge clk_2);
        reset_n = 1'b1;
        @(negedge clk_2);

        // LOAD 9, then RUN_UP paced by the prescaler
        apply_stimulus(OP_LOAD, 4'd9, t);
        expect_at(t, "load_state", F_STATE, 1);
        expect_at(t, "load_ready_low", F_READY, 0);
        expect_at(t + 1, "load_count", F_COUNT, 9);
        expect_at(t + 1, "load_ready_back", F_READY, 1);
        expect_at(t + 1, "load_idle", F_STATE, 0);
        wait_drain();
        apply_stimulus(OP_RUN_UP, 4'd0, t);
        expect_at(t, "run_running", F_RUN, 1);
        expect_at(t, "run_state", F_STATE, 2);
        expect_at(t + 3, "run_no_early_step", F_COUNT, 9);
        expect_at(t + 4, "run_step1", F_COUNT, 10);
        expect_at(t + 8, "run_step2", F_COUNT, 11);
        expect_at(t + 12, "run_step3", F_COUNT, 12);
        wait_drain();
        do_stop("run_stop");

        // Wrap from 15 to 0, then STOP on a tick edge
        do_load(4'd14, "wrap_load");
        apply_stimulus(OP_RUN_UP, 4'd0, t);
        expect_at(t + 4, "wrap_15", F_COUNT, 15);
        expect_at(t + 8, "wrap_0", F_COUNT, 0);
        expect_at(t + 12, "wrap_1", F_COUNT, 1);
        wait_drain();
        wait_edge(t + 15);
        apply_stimulus(OP_STOP, 4'd0, s);
        check_output("stop_accept_edge", s, t + 16);
        expect_at(s, "stop_tick_count", F_COUNT, 1);
        expect_at(s, "stop_tick_running", F_RUN, 0);
        expect_at(s, "stop_tick_state", F_STATE, 0);
        expect_at(s + 5, "stop_count_held", F_COUNT, 1);
        wait_drain();

        // Bounce at the top limit
        bounce = 1'b1;
        do_load(4'd14, "bounce_load");
        apply_stimulus(OP_RUN_UP, 4'd0, t);
        expect_at(t + 4, "bounce_15", F_COUNT, 15);
        expect_at(t + 4, "bounce_dir_up", F_DIR, 1);
        expect_at(t + 8, "bounce_14", F_COUNT, 14);
        expect_at(t + 8, "bounce_dir_down", F_DIR, 0);
        expect_at(t + 12, "bounce_13", F_COUNT, 13);
        expect_at(t + 12, "bounce_dir_still_down", F_DIR, 0);
        wait_drain();
        do_stop("bounce_stop");
        bounce = 1'b0;

        // Stop at target 0 while counting down; LOAD held through DONE
        do_load(4'd2, "target_load");
        target_en = 1'b1;
        target    = 4'd0;
        apply_stimulus(OP_RUN_DOWN, 4'd0, t);
        expect_at(t, "target_dir", F_DIR, 0);
        expect_at(t + 4, "target_step1", F_COUNT, 1);
        expect_at(t + 7, "target_no_early_done", F_DONE, 0);
        expect_at(t + 8, "target_step0", F_COUNT, 0);
        expect_at(t + 8, "target_state_done", F_STATE, 3);
        expect_at(t + 8, "target_done_pulse", F_DONE, 1);
        expect_at(t + 8, "target_ready_low", F_READY, 0);
        expect_at(t + 9, "target_done_clear", F_DONE, 0);
        expect_at(t + 9, "target_state_idle", F_STATE, 0);
        expect_at(t + 9, "target_count_hold", F_COUNT, 0);
        wait_edge(t + 8);
        apply_stimulus(OP_LOAD, 4'd5, s);
        check_output("held_accept_edge", s, t + 10);
        expect_at(s + 1, "held_load_count", F_COUNT, 5);
        wait_drain();
        target_en = 1'b0;

        // Asynchronous reset in the middle of a down-count
        apply_stimulus(OP_RUN_DOWN, 4'd0, t);
        expect_at(t + 4, "pre_reset_step", F_COUNT, 4);
        expect_at(t + 4, "pre_reset_dir", F_DIR, 0);
        wait_drain();
        #1 reset_n = 1'b0;
        #1;
        check_output("arst_count", int'(count), 0);
        check_output("arst_dir", int'(dir_up), 1);
        check_output("arst_running", int'(running), 0);
        check_output("arst_done", int'(done), 0);
        check_output("arst_ready", int'(cmd_ready), 1);
        check_output("arst_state", int'(seq_state), 0);
        @(negedge clk_2);
        reset_n = 1'b1;
        expect_at(edge_cnt + 8, "post_reset_count", F_COUNT, 0);
        expect_at(edge_cnt + 8, "post_reset_running", F_RUN, 0);
        wait_drain();

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
